// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL manager terminating A/D on a byte-maskable word RAM with a one-entry response register.
// Optional out-of-range address refusal: define TL_RAM_RESPONDER_OOR_CHECK_EN.
module tl_ul_ram_responder #(
  parameter int  DEPTH    = 256,
  parameter int  SOURCE_W = 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                d_corrupt
);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  logic [31:0]         mem_r [DEPTH];
  logic                d_valid_r;
  logic [2:0]          d_opcode_r;
  logic [1:0]          d_size_r;
  logic [SOURCE_W-1:0] d_source_r;
  logic                d_denied_r;
  logic [31:0]         d_data_r;
  logic                d_corrupt_r;

  logic                a_ready_s;
  logic                a_fire_s;
  logic                d_fire_s;
  logic                is_put_s;
  logic                is_get_s;
  logic                oor_s;
  logic                denied_s;
  logic                wr_en_s;
  logic [AW-1:0]       idx_s;
  logic [2:0]          rsp_opcode_s;
  logic [31:0]         rsp_data_s;
  logic                rsp_corrupt_s;
  logic                unused_s;

  assign idx_s     = a_address[AW+1:2];
  assign a_ready_s = ~reset & (~d_valid_r | d_ready);
  assign a_fire_s  = a_valid & a_ready_s;
  assign d_fire_s  = d_valid_r & d_ready;
  assign unused_s  = ^{a_param, a_address[1:0], a_address[31:AW+2]};

`ifdef TL_RAM_RESPONDER_OOR_CHECK_EN
  assign oor_s = |a_address[31:AW+2];
`else
  assign oor_s = 1'b0;
`endif

  // Decode the incoming request into the response it will produce.
  always_comb begin
    is_put_s = 1'b0;
    is_get_s = 1'b0;
    case (a_opcode)
      OP_PUT_FULL, OP_PUT_PART: is_put_s = 1'b1;
      OP_GET:                   is_get_s = 1'b1;
      default: begin
        is_put_s = 1'b0;
        is_get_s = 1'b0;
      end
    endcase
    denied_s      = ~(is_put_s | is_get_s) | oor_s;
    rsp_opcode_s  = is_get_s ? OP_ACK_DATA : OP_ACK;
    rsp_corrupt_s = is_get_s & denied_s;
    if (is_get_s && !denied_s) begin
      rsp_data_s = mem_r[idx_s];
    end else begin
      rsp_data_s = 32'd0;
    end
  end

  assign wr_en_s = a_fire_s & is_put_s & ~oor_s;

  // Byte-lane writes; the array is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (a_mask[i]) begin
          mem_r[idx_s][8*i +: 8] <= a_data[8*i +: 8];
        end
      end
    end
  end

  // Response register: a new request overwrites, a bare D handshake empties it.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid_r   <= 1'b0;
      d_opcode_r  <= 3'd0;
      d_size_r    <= 2'd0;
      d_source_r  <= '0;
      d_denied_r  <= 1'b0;
      d_data_r    <= 32'd0;
      d_corrupt_r <= 1'b0;
    end else if (a_fire_s) begin
      d_valid_r   <= 1'b1;
      d_opcode_r  <= rsp_opcode_s;
      d_size_r    <= a_size;
      d_source_r  <= a_source;
      d_denied_r  <= denied_s;
      d_data_r    <= rsp_data_s;
      d_corrupt_r <= rsp_corrupt_s;
    end else if (d_fire_s) begin
      d_valid_r   <= 1'b0;
    end else begin
      d_valid_r   <= d_valid_r;
    end
  end

  assign a_ready   = a_ready_s;
  assign d_valid   = d_valid_r;
  assign d_opcode  = d_opcode_r;
  assign d_param   = 2'd0;
  assign d_size    = d_size_r;
  assign d_source  = d_source_r;
  assign d_denied  = d_denied_r;
  assign d_data    = d_data_r;
  assign d_corrupt = d_corrupt_r;

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Directed bench for tl_ul_ram_responder with a response scoreboard.
// Expectations follow TL_RAM_RESPONDER_OOR_CHECK_EN when it is defined.
module tb_tl_ul_ram_responder;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [1:0]  size;
    logic [3:0]  source;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [1:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;

  int          vectors = 0;
  int          miscompares = 0;
  resp_t       sb_q[$];
  logic [31:0] mem_m [256];

  always #5 clk = ~clk;

  tl_ul_ram_responder #(.DEPTH(256), .SOURCE_W(4)) dut (
    .clock(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
    .d_corrupt(d_corrupt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic resp_t obs_resp();
    resp_t o;
    o.opcode  = d_opcode;
    o.param   = d_param;
    o.size    = d_size;
    o.source  = d_source;
    o.denied  = d_denied;
    o.data    = d_data;
    o.corrupt = d_corrupt;
    return o;
  endfunction

  // Reference behaviour of one accepted request; updates the model RAM.
  task automatic push_req();
    resp_t       e;
    logic [7:0]  idx;
    logic        oor;
    idx = a_address[9:2];
`ifdef TL_RAM_RESPONDER_OOR_CHECK_EN
    oor = |a_address[31:10];
`else
    oor = 1'b0;
`endif
    e        = '0;
    e.size   = a_size;
    e.source = a_source;
    case (a_opcode)
      3'd0, 3'd1: begin
        e.opcode = 3'd0;
        e.denied = oor;
        if (!oor) begin
          for (int i = 0; i < 4; i++) begin
            if (a_mask[i]) mem_m[idx][8*i +: 8] = a_data[8*i +: 8];
          end
        end
      end
      3'd4: begin
        e.opcode  = 3'd1;
        e.denied  = oor;
        e.corrupt = oor;
        e.data    = oor ? 32'd0 : mem_m[idx];
      end
      default: begin
        e.opcode = 3'd0;
        e.denied = 1'b1;
      end
    endcase
    sb_q.push_back(e);
  endtask

  // One clock: score the D handshake and the A handshake, then advance.
  task automatic cyc(input string tag);
    resp_t e;
    @(negedge clk);
    if (d_valid && d_ready) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_unexpected"}, 64'(d_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk(tag, 64'(obs_resp()), 64'(e));
      end
    end
    if (a_valid && a_ready) push_req();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [1:0] sz, input logic [3:0] src,
                     input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_param   = 3'd0;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 2'd0;
    a_source = 4'd0; a_address = 32'd0; a_mask = 4'd0; a_data = 32'd0; d_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("reset_state", 64'({a_ready, d_valid, d_opcode, d_param, d_size, d_source,
                            d_denied, d_data, d_corrupt}), 64'd0);
    reset = 1'b0;
    cyc("idle0");
    chk("a_ready_out_of_reset", 64'(a_ready), 64'd1);

    // Basic put/get, partial merge, boundary indices.
    req(3'd0, 2'd2, 4'd3, 32'h10, 4'hF, 32'hDEADBEEF);  cyc("put_full");
    chk("put_latency", 64'({d_valid, d_source}), 64'({1'b1, 4'd3}));
    req(3'd4, 2'd2, 4'd5, 32'h10, 4'hF, 32'h0);         cyc("put_full_ack");
    req(3'd1, 2'd1, 4'd6, 32'h10, 4'h5, 32'h11223344);  cyc("get_deadbeef");
    req(3'd4, 2'd2, 4'd7, 32'h10, 4'hF, 32'h0);         cyc("put_partial_ack");
    req(3'd0, 2'd2, 4'd1, 32'h0, 4'hF, 32'hA5A50001);   cyc("get_merged");
    req(3'd0, 2'd0, 4'd2, 32'h3FC, 4'hF, 32'h12345678); cyc("put_idx0_ack");
    req(3'd4, 2'd0, 4'd8, 32'h3FC, 4'hF, 32'h0);        cyc("put_idx255_ack");
    req(3'd4, 2'd1, 4'd9, 32'h0, 4'hF, 32'h0);          cyc("get_idx255");
    a_valid = 1'b0;                                      cyc("get_idx0");
    cyc("idle1");
    chk("d_valid_clears", 64'(d_valid), 64'd0);

    // Back-pressure: one response held, next request stalls for five cycles.
    d_ready = 1'b0;
    req(3'd4, 2'd2, 4'd10, 32'h10, 4'hF, 32'h0);        cyc("bp_issue");
    req(3'd0, 2'd2, 4'd11, 32'h20, 4'hF, 32'hCAFEF00D);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_a_ready", 64'(a_ready), 64'd0);
      chk("bp_hold", 64'(obs_resp()), 64'(sb_q[0]));
      @(posedge clk);
      #1;
    end
    d_ready = 1'b1;                                      cyc("bp_release_get");
    chk("bp_stream_valid", 64'(d_valid), 64'd1);
    req(3'd4, 2'd2, 4'd12, 32'h20, 4'hF, 32'h0);        cyc("bp_put_ack");
    req(3'd4, 2'd2, 4'd13, 32'h3FC, 4'hF, 32'h0);       cyc("bp_get_cafe");

    // Unsupported opcodes leave memory untouched.
    req(3'd2, 2'd2, 4'd14, 32'h10, 4'hF, 32'hFFFFFFFF); cyc("get_idx255_again");
    req(3'd7, 2'd2, 4'd15, 32'h10, 4'hF, 32'hFFFFFFFF); cyc("op2_denied");
    req(3'd4, 2'd2, 4'd1, 32'h10, 4'hF, 32'h0);         cyc("op7_denied");

    // Upper address bits: alias or out-of-range depending on build.
    req(3'd4, 2'd2, 4'd2, 32'h400, 4'hF, 32'h0);        cyc("get_after_denied");
    req(3'd0, 2'd2, 4'd3, 32'h4, 4'hF, 32'h11110000);   cyc("get_0x400");
    req(3'd0, 2'd2, 4'd4, 32'h404, 4'hF, 32'h0BADC0DE); cyc("put_0x4_ack");
    req(3'd4, 2'd2, 4'd5, 32'h4, 4'hF, 32'h0);          cyc("put_0x404_ack");
    a_valid = 1'b0;                                      cyc("get_0x4");

    // Reset while a response is pending; concurrent request must not write.
    d_ready = 1'b0;
    req(3'd0, 2'd2, 4'd5, 32'h10, 4'hF, 32'h55AA55AA);  cyc("pre_reset_put");
    reset = 1'b1;
    req(3'd0, 2'd2, 4'd6, 32'h10, 4'hF, 32'h0);         cyc("in_reset");
    chk("reset_discard", 64'(d_valid), 64'd0);
    void'(sb_q.pop_front());
    reset = 1'b0; a_valid = 1'b0; d_ready = 1'b1;        cyc("post_reset");
    req(3'd4, 2'd2, 4'd7, 32'h10, 4'hF, 32'h0);         cyc("post_reset_get_issue");
    a_valid = 1'b0;                                      cyc("get_after_reset");

    for (int k = 0; k < 4 && sb_q.size() > 0; k++) cyc("drain");
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
